// File: rtl/hazard_unit.sv
// EX-stage hazard controller: tracks E/M/W destination metadata, drives forwarding
// selects, load-use stall/bubble, branch flush, memory-busy freeze and a stall counter.
module hazard_unit #(
   parameter int REG_AW = 3,
   parameter int CNT_W  = 16
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_D_valid,
   input  logic [REG_AW-1:0] i_D_src1,
   input  logic [REG_AW-1:0] i_D_src2,
   input  logic              i_D_src1_used,
   input  logic              i_D_src2_alu,
   input  logic              i_D_store,
   input  logic [REG_AW-1:0] i_D_dst,
   input  logic              i_D_reg_write,
   input  logic              i_D_mem_read,
   input  logic              i_Branch_Taken,
   input  logic              i_mem_busy,
   output logic [1:0]        o_oper1_sel,
   output logic [1:0]        o_oper2_sel,
   output logic [1:0]        o_Write_Data_sel,
   output logic              o_stall,
   output logic              o_flush_D,
   output logic              o_flush_E,
   output logic              o_freeze,
   output logic [CNT_W-1:0]  o_stall_cycles
);

   logic              e_valid, e_src1_used, e_src2_alu, e_store, e_reg_write, e_mem_read;
   logic [REG_AW-1:0] e_src1, e_src2, e_dst;
   logic              m_valid, m_reg_write, m_mem_read;
   logic [REG_AW-1:0] m_dst;
   logic              w_valid, w_reg_write;
   logic [REG_AW-1:0] w_dst;

   logic m_fwd_en, w_fwd_en, load_use, branch_flush;

   // A load in MEM has no result yet, so it never forwards from that stage.
   assign m_fwd_en = m_valid & m_reg_write & ~m_mem_read;
   assign w_fwd_en = w_valid & w_reg_write;

   function automatic logic [1:0] fwd_sel(
      input logic              use_f,
      input logic [REG_AW-1:0] src,
      input logic              m_en,
      input logic [REG_AW-1:0] m_d,
      input logic              w_en,
      input logic [REG_AW-1:0] w_d
   );
      logic [1:0] sel;
      sel = 2'b00;
      if (use_f) begin
         if (m_en && m_d == src)
            sel = 2'b10;
         else if (w_en && w_d == src)
            sel = 2'b01;
      end
      return sel;
   endfunction

   assign o_oper1_sel      = fwd_sel(e_valid & e_src1_used, e_src1, m_fwd_en, m_dst, w_fwd_en, w_dst);
   assign o_oper2_sel      = fwd_sel(e_valid & e_src2_alu,  e_src2, m_fwd_en, m_dst, w_fwd_en, w_dst);
   assign o_Write_Data_sel = fwd_sel(e_valid & e_store,     e_src2, m_fwd_en, m_dst, w_fwd_en, w_dst);

   assign load_use = e_valid & e_mem_read & e_reg_write & i_D_valid &
                     ((i_D_src1_used & (e_dst == i_D_src1)) |
                      ((i_D_src2_alu | i_D_store) & (e_dst == i_D_src2)));

   // Reset gates the branch term so flushes drop immediately on an async reset.
   assign branch_flush = i_Branch_Taken & ~i_mem_busy & i_rst_n;

   assign o_freeze  = i_mem_busy;
   assign o_flush_D = branch_flush;
   assign o_stall   = load_use & ~i_Branch_Taken & ~i_mem_busy;
   assign o_flush_E = branch_flush | o_stall;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         e_valid     <= 1'b0;
         e_src1      <= '0;
         e_src2      <= '0;
         e_src1_used <= 1'b0;
         e_src2_alu  <= 1'b0;
         e_store     <= 1'b0;
         e_dst       <= '0;
         e_reg_write <= 1'b0;
         e_mem_read  <= 1'b0;
         m_valid     <= 1'b0;
         m_dst       <= '0;
         m_reg_write <= 1'b0;
         m_mem_read  <= 1'b0;
         w_valid     <= 1'b0;
         w_dst       <= '0;
         w_reg_write <= 1'b0;
      end else if (!i_mem_busy) begin
         e_valid     <= i_D_valid & ~o_flush_E;
         e_src1      <= i_D_src1;
         e_src2      <= i_D_src2;
         e_src1_used <= i_D_src1_used;
         e_src2_alu  <= i_D_src2_alu;
         e_store     <= i_D_store;
         e_dst       <= i_D_dst;
         e_reg_write <= i_D_reg_write;
         e_mem_read  <= i_D_mem_read;
         m_valid     <= e_valid;
         m_dst       <= e_dst;
         m_reg_write <= e_reg_write;
         m_mem_read  <= e_mem_read;
         w_valid     <= m_valid;
         w_dst       <= m_dst;
         w_reg_write <= m_reg_write;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         o_stall_cycles <= '0;
      else if ((o_stall | o_freeze) && (o_stall_cycles != {CNT_W{1'b1}}))
         o_stall_cycles <= o_stall_cycles + 1'b1;
   end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller paired with the EX stage. It tracks destination-register metadata for the instructions in EX, MEM and WB and drives the three EX forwarding-mux selects: ALU operand 1, ALU operand 2 and store data. It also detects load-use hazards and issues stall and bubble controls, and it flushes fetch/decode when EX reports a taken branch. A global freeze handles a busy data memory.

## Interface
- REG_AW, 3: register index width (2^REG_AW architectural registers; no hardwired-zero register).
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_D_valid  in  1  decode holds a real instruction.
- i_D_src1, i_D_src2  in  REG_AW  source register indices of the decode instruction.
- i_D_src1_used  in  1  src1 feeds ALU operand 1.
- i_D_src2_alu  in  1  src2 feeds ALU operand 2; else operand 2 is immediate/temp.
- i_D_store  in  1  src2 is store data.
- i_D_dst  in  REG_AW  destination index.
- i_D_reg_write  in  1  instruction writes the register file.
- i_D_mem_read  in  1  instruction is a load.
- i_Branch_Taken  in  1  from EX, qualified taken branch.
- i_mem_busy  in  1  data memory not ready; freezes the pipe.
- o_oper1_sel, o_oper2_sel, o_Write_Data_sel  out  2  forwarding selects: 00 register/temp, 01 WB value, 10 MEM ALU result; 11 never driven.
- o_stall  out  1  hold PC and the IF/ID register.
- o_flush_D  out  1  clear the IF/ID register.
- o_flush_E  out  1  clear the ID/EX register (bubble).
- o_freeze  out  1  hold all pipeline registers and the SR register.
- o_stall_cycles  out  CNT_W  saturating count of cycles with o_stall or o_freeze high.

## Operation
- Three internal shadow stages: E, M, W. Each holds valid, src1/src2 and their use flags (E only), dst, reg_write and mem_read.
- Advance on each clock when o_freeze=0: D→E, E→M, M→W. When o_flush_E=1, E loads a bubble (valid=0).
- When o_freeze=1, all shadow stages hold.
- Forwarding for the E instruction, per operand (src1 with src1_used; src2 with src2_alu; src2 with store):
  - 10 if M.valid & M.reg_write & !M.mem_read & M.dst==src.
  - Else 01 if W.valid & W.reg_write & W.dst==src.
  - Else 00.
  - An operand whose use flag is 0, or with E.valid=0, gets 00.
- Load-use hazard: E.valid & E.mem_read & E.reg_write & i_D_valid & ((i_D_src1_used & E.dst==i_D_src1) | ((i_D_src2_alu | i_D_store) & E.dst==i_D_src2)).
- Outputs are combinational from the shadow state and inputs:
  - o_freeze = i_mem_busy.
  - o_flush_D = o_flush_E(branch) = i_Branch_Taken & !i_mem_busy.
  - On load-use with no branch and no freeze: o_stall=1 and o_flush_E=1.
  - o_flush_E = branch flush OR load-use bubble.
- Priority: freeze > branch flush > load-use stall. A taken branch suppresses o_stall, because the dependent instruction is squashed.
- Counter: increments by 1 per cycle when (o_stall | o_freeze) and holds at all-ones.

## Timing
- Reset: all shadow valid bits 0, o_stall_cycles=0. As a result all selects are 00 and o_stall, o_flush_D and o_flush_E are 0. o_freeze follows i_mem_busy even during reset.
- The selects are valid in the same cycle the instruction occupies EX; zero added latency.
- Load-use sequence:
  - Cycle N: load in E, dependent in D; o_stall=1, o_flush_E=1.
  - Cycle N+1: load in M, bubble in E; no stall.
  - Cycle N+2: dependent in E, load in W; that operand's select is 01.
- Back-to-back ALU dependency: no stall; select is 10 in the consumer's EX cycle.
- Branch: i_Branch_Taken in cycle N gives flushes in cycle N. At the N+1 edge, E and IF/ID receive bubbles.
- Freeze mid-branch: flushes are held low while frozen and assert in the first unfrozen cycle (EX holds the branch, so i_Branch_Taken stays high).
- Reset asserted mid-operation: shadow state clears immediately (asynchronous). Pending stalls and flushes drop in the same cycle.

## Test plan
- Reset, then ADD r1 followed by SUB r2=r1+r3: no stall; o_oper1_sel=10 in the SUB EX cycle, 00 elsewhere.
- r1 written by instructions in both M and W while E reads r1 on op1 and op2: both selects=10 (MEM priority). Retire the M writer: selects=01.
- LOAD r4 then ADD using r4 on op2: exactly one cycle of o_stall=1, o_flush_E=1; two cycles later o_oper2_sel=01; o_stall_cycles=1.
- LOAD r4 then STORE r4 as data: one-cycle stall, then o_Write_Data_sel=01, o_oper1_sel=00.
- Taken branch in E while a load-use hazard is present in D: o_flush_D=o_flush_E=1, o_stall=0. Repeat with i_mem_busy=1 for 3 cycles: flushes are 0 for those cycles and fire on the 4th; o_stall_cycles=3.
- Drive o_stall continuously for 2^CNT_W+5 cycles: o_stall_cycles saturates at all-ones. Assert i_rst_n=0 asynchronously mid-stall: counter and selects clear before the next edge.
